// File: rtl/dvi_timing_sequencer_pkg.sv
// Shared timing constants, control-word bit positions and the colour bar table
// for the DVI timing sequencer.
package dvi_timing_sequencer_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int CTRL_HSYNC = 0;
    localparam int CTRL_VSYNC = 1;

    function automatic logic [1:0] ctrl_word(input logic vs, input logic hs);
        logic [1:0] w;
        w             = 2'b00;
        w[CTRL_VSYNC] = vs;
        w[CTRL_HSYNC] = hs;
        return w;
    endfunction

    // Bars are {R,G,B}, left to right.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvi_timing_sequencer_axis.sv
// dvi_axis_counter: one raster axis (horizontal or vertical) position counter
// with active / sync region flags and a wrap strobe.
module dvi_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CW     = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_step,
    output logic [CW-1:0] o_pos,
    output logic          o_active,
    output logic          o_sync,
    output logic          o_wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

    generate
        if (TOTAL > (2 ** CW) - 1) begin : g_total_check
            $error("dvi_axis_counter: total %0d does not fit in %0d bits", TOTAL, CW);
        end
    endgenerate

    logic [CW-1:0] pos_r;

    // Position register: advances on i_step, wraps after the last position.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pos_r <= {CW{1'b0}};
        end else if (i_step && (pos_r == LAST)) begin
            pos_r <= {CW{1'b0}};
        end else if (i_step) begin
            pos_r <= pos_r + CW'(1);
        end else begin
            pos_r <= pos_r;
        end
    end

    assign o_pos    = pos_r;
    assign o_active = (pos_r < ACT_END);
    assign o_sync   = (pos_r >= SYNC_START) && (pos_r < SYNC_END);
    assign o_wrap   = i_step && (pos_r == LAST);

endmodule

// File: rtl/dvi_timing_sequencer.sv
// DVI raster timing sequencer feeding three TMDS encoders.
// Optional colour bar generator enabled by defining DVI_TEST_PATTERN_EN.
module dvi_timing_sequencer
    import dvi_timing_sequencer_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
`ifdef DVI_TEST_PATTERN_EN
    input  logic          i_pattern,
`endif
    input  logic          i_px_valid,
    input  logic [23:0]   i_px_data,
    output logic          o_px_ready,
    output logic          o_de,
    output logic [1:0]    o_ctrl0,
    output logic [1:0]    o_ctrl1,
    output logic [1:0]    o_ctrl2,
    output logic [7:0]    o_blue,
    output logic [7:0]    o_green,
    output logic [7:0]    o_red,
    output logic [CW-1:0] o_sx,
    output logic [CW-1:0] o_sy,
    output logic          o_frame_start,
    output logic          o_underflow,
    output logic [15:0]   o_underflow_cnt
);

    localparam logic [1:0] CTRL_IDLE = ctrl_word(~V_POL, ~H_POL);

    logic [CW-1:0] h_pos_s, v_pos_s;
    logic          h_active_s, h_sync_s, h_wrap_s;
    logic          v_active_s, v_sync_s, v_wrap_s;
    logic          active_s, uf_s;
    logic [23:0]   stream_pix_s, pix_s;
    logic          start_pend_r;

    dvi_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
    ) u_hcnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_step(1'b1),
        .o_pos(h_pos_s), .o_active(h_active_s), .o_sync(h_sync_s), .o_wrap(h_wrap_s)
    );

    dvi_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
    ) u_vcnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_step(h_wrap_s),
        .o_pos(v_pos_s), .o_active(v_active_s), .o_sync(v_sync_s), .o_wrap(v_wrap_s)
    );

    assign active_s     = h_active_s && v_active_s;
    assign stream_pix_s = (active_s && i_px_valid) ? i_px_data : 24'h000000;
    assign o_ctrl1      = 2'b00;
    assign o_ctrl2      = 2'b00;

`ifdef DVI_TEST_PATTERN_EN
    // Bar index tracks (hc*8)/H_ACTIVE by stepping a remainder 8 units per pixel.
    logic [CW-1:0] bar_acc_r, bar_acc_s;
    logic [3:0]    bar_idx_r, bar_idx_s;

    // Next remainder/index for the following pixel of the line.
    always_comb begin
        bar_acc_s = bar_acc_r;
        bar_idx_s = bar_idx_r;
        for (int i = 0; i < 8; i++) begin
            if (bar_acc_s == CW'(H_ACTIVE - 1)) begin
                bar_acc_s = {CW{1'b0}};
                bar_idx_s = bar_idx_s + 4'd1;
            end else begin
                bar_acc_s = bar_acc_s + CW'(1);
            end
        end
    end

    // Bar step state, cleared at every line start.
    always_ff @(posedge i_clk) begin
        if (i_rst || h_wrap_s) begin
            bar_acc_r <= {CW{1'b0}};
            bar_idx_r <= 4'd0;
        end else begin
            bar_acc_r <= bar_acc_s;
            bar_idx_r <= bar_idx_s;
        end
    end

    // Pixel source select: colour bars or upstream stream.
    always_comb begin
        pix_s = stream_pix_s;
        if (i_pattern) begin
            if (active_s) begin
                pix_s = bar_rgb(bar_idx_r[2:0]);
            end else begin
                pix_s = 24'h000000;
            end
        end else begin
            pix_s = stream_pix_s;
        end
    end

    assign o_px_ready = active_s && !i_rst && !i_pattern;
    assign uf_s       = active_s && !i_px_valid && !i_pattern;
`else
    assign pix_s      = stream_pix_s;
    assign o_px_ready = active_s && !i_rst;
    assign uf_s       = active_s && !i_px_valid;
`endif

    // Registered encoder inputs, position, pulses and underflow statistics.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_de            <= 1'b0;
            o_ctrl0         <= CTRL_IDLE;
            {o_red, o_green, o_blue} <= 24'h000000;
            o_sx            <= {CW{1'b0}};
            o_sy            <= {CW{1'b0}};
            o_frame_start   <= 1'b0;
            o_underflow     <= 1'b0;
            o_underflow_cnt <= 16'h0000;
            start_pend_r    <= 1'b1;
        end else begin
            o_de            <= active_s;
            o_ctrl0         <= ctrl_word(V_POL ? v_sync_s : ~v_sync_s,
                                         H_POL ? h_sync_s : ~h_sync_s);
            {o_red, o_green, o_blue} <= pix_s;
            o_sx            <= h_pos_s;
            o_sy            <= v_pos_s;
            // Counter sits at (0,0) right after reset or a frame wrap.
            o_frame_start   <= start_pend_r;
            start_pend_r    <= v_wrap_s;
            o_underflow     <= uf_s;
            if (uf_s && (o_underflow_cnt != 16'hFFFF)) begin
                o_underflow_cnt <= o_underflow_cnt + 16'd1;
            end else begin
                o_underflow_cnt <= o_underflow_cnt;
            end
        end
    end

endmodule

// File: tb/tb_dvi_timing_sequencer.sv
// Randomized self-checking bench for dvi_timing_sequencer against a raster
// model; a second large-raster instance exercises underflow counter saturation.
module tb_dvi_timing_sequencer;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int SHA = 125, SVA = 253;
    localparam int SHT = SHA + 3, SVT = SVA + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- main DUT ----------------
    logic        rst, valid, pat;
    logic [23:0] data;
    logic        o_px_ready, o_de, o_frame_start, o_underflow;
    logic [1:0]  o_ctrl0, o_ctrl1, o_ctrl2;
    logic [7:0]  o_blue, o_green, o_red;
    logic [9:0]  o_sx, o_sy;
    logic [15:0] o_underflow_cnt;

    dvi_timing_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .CW(10)
    ) dut (
        .i_clk(clk), .i_rst(rst),
`ifdef DVI_TEST_PATTERN_EN
        .i_pattern(pat),
`endif
        .i_px_valid(valid), .i_px_data(data), .o_px_ready(o_px_ready),
        .o_de(o_de), .o_ctrl0(o_ctrl0), .o_ctrl1(o_ctrl1), .o_ctrl2(o_ctrl2),
        .o_blue(o_blue), .o_green(o_green), .o_red(o_red),
        .o_sx(o_sx), .o_sy(o_sy), .o_frame_start(o_frame_start),
        .o_underflow(o_underflow), .o_underflow_cnt(o_underflow_cnt)
    );

    // ---------------- saturation DUT ----------------
    logic        s_rst;
    logic        s_px_ready, s_de, s_frame_start, s_underflow;
    logic [1:0]  s_ctrl0, s_ctrl1, s_ctrl2;
    logic [7:0]  s_blue, s_green, s_red;
    logic [9:0]  s_sx, s_sy;
    logic [15:0] s_underflow_cnt;
    logic        sat_done = 1'b0;

    dvi_timing_sequencer #(
        .H_ACTIVE(SHA), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(SVA), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .CW(10)
    ) dut_sat (
        .i_clk(clk), .i_rst(s_rst),
`ifdef DVI_TEST_PATTERN_EN
        .i_pattern(1'b0),
`endif
        .i_px_valid(1'b0), .i_px_data(24'h000000), .o_px_ready(s_px_ready),
        .o_de(s_de), .o_ctrl0(s_ctrl0), .o_ctrl1(s_ctrl1), .o_ctrl2(s_ctrl2),
        .o_blue(s_blue), .o_green(s_green), .o_red(s_red),
        .o_sx(s_sx), .o_sy(s_sy), .o_frame_start(s_frame_start),
        .o_underflow(s_underflow), .o_underflow_cnt(s_underflow_cnt)
    );

    // ---------------- reference model ----------------
    int          mx, my, m_cnt;
    logic        e_de, e_fs, e_uf;
    logic [1:0]  e_ctrl0;
    logic [23:0] e_rgb;
    int          e_sx, e_sy;

    function automatic logic [23:0] bar_color(input int i);
        logic [23:0] tbl [8];
        tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return tbl[i];
    endfunction

    // One pixel clock: check ready for the current position, predict, then check outputs.
    task automatic step();
        logic act, hs, vs, uf;
        @(negedge clk);
        act = (mx < HA) && (my < VA);
        check_eq("px_ready", o_px_ready, !rst && act && !pat);
        if (rst) begin
            e_de = 1'b0; e_ctrl0 = 2'b11; e_rgb = 24'h0; e_sx = 0; e_sy = 0;
            e_fs = 1'b0; e_uf = 1'b0; m_cnt = 0; mx = 0; my = 0;
        end else begin
            hs = (mx >= HA + HF) && (mx < HA + HF + HS);
            vs = (my >= VA + VF) && (my < VA + VF + VS);
            uf = act && !valid && !pat;
            e_de    = act;
            e_ctrl0 = {!vs, !hs};
            if (pat) e_rgb = act ? bar_color((mx * 8) / HA) : 24'h0;
            else     e_rgb = (act && valid) ? data : 24'h0;
            e_uf  = uf;
            m_cnt = (m_cnt + int'(uf) > 65535) ? 65535 : m_cnt + int'(uf);
            e_fs  = (mx == 0) && (my == 0);
            e_sx  = mx; e_sy = my;
            mx = (mx + 1) % HT;
            if (mx == 0) my = (my + 1) % VT;
        end
        @(posedge clk); #1;
        check_eq("de", o_de, e_de);
        check_eq("ctrl0", o_ctrl0, e_ctrl0);
        check_eq("ctrl12", {o_ctrl1, o_ctrl2}, 4'h0);
        check_eq("rgb", {o_red, o_green, o_blue}, e_rgb);
        check_eq("sx", o_sx, e_sx);
        check_eq("sy", o_sy, e_sy);
        check_eq("frame_start", o_frame_start, e_fs);
        check_eq("underflow", o_underflow, e_uf);
        check_eq("uf_cnt", o_underflow_cnt, m_cnt);
    endtask

    // Main sequence.
    initial begin
        int k;
        bit hit;
        rst = 1'b1; valid = 1'b0; data = 24'h0; pat = 1'b0;
        mx = 0; my = 0; m_cnt = 0;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;

        // Full frame of valid incrementing data.
        for (k = 0; k < 48; k++) begin
            valid = 1'b1; data = 24'(k + 1);
            step();
        end

        // Drop the pixel that will appear at output (2,1).
        for (k = 0; k < 48; k++) begin
            valid = !((mx == 2) && (my == 1));
            data  = 24'($urandom);
            step();
        end
        check_eq("uf_cnt_one", o_underflow_cnt, 16'd1);

        // Random valid/data.
        for (k = 0; k < 300; k++) begin
            valid = ($urandom_range(0, 3) != 0);
            data  = 24'($urandom);
            step();
        end

        // Reset mid-frame once output shows (3,2).
        hit = 1'b0;
        for (k = 0; k < 100 && !hit; k++) begin
            valid = 1'b1; data = 24'($urandom);
            step();
            hit = (o_sx == 10'd3) && (o_sy == 10'd2);
        end
        check_eq("reach_3_2", hit, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (k = 0; k < 60; k++) begin
            valid = ($urandom_range(0, 4) != 0);
            data  = 24'($urandom);
            step();
        end

`ifdef DVI_TEST_PATTERN_EN
        pat = 1'b1;
        for (k = 0; k < 60; k++) begin
            valid = $urandom_range(0, 1) != 0;
            data  = 24'($urandom);
            step();
        end
        pat = 1'b0;
        for (k = 0; k < 20; k++) begin
            valid = 1'b1; data = 24'($urandom);
            step();
        end
`endif

        for (k = 0; k < 100000 && !sat_done; k++) @(posedge clk);
        check_eq("sat_done", sat_done, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Saturation run: valid held low until the count pins at FFFF.
    initial begin
        int sx2, sy2, scnt, extra;
        logic act;
        s_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s_rst = 1'b0;
        sx2 = 0; sy2 = 0; scnt = 0; extra = 0;
        for (int n = 0; n < 90000 && extra < 600; n++) begin
            act = (sx2 < SHA) && (sy2 < SVA);
            @(posedge clk); #1;
            if (act && scnt < 65535) scnt++;
            if (scnt == 65535) extra++;
            sx2 = (sx2 + 1) % SHT;
            if (sx2 == 0) sy2 = (sy2 + 1) % SVT;
            check_eq("sat_cnt", s_underflow_cnt, scnt);
            check_eq("sat_pulse", s_underflow, act);
        end
        check_eq("sat_hold", s_underflow_cnt, 16'hFFFF);
        sat_done = 1'b1;
    end

endmodule
